// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one outstanding request, req/rsp valid-ready handshakes.
// Define DMEM_WAIT_STATE_EN to insert WAIT_CYCLES wait states before each access completes.
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

`ifdef DMEM_WAIT_STATE_EN
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);
`else
    typedef enum logic [1:0] {IDLE, RESP} state_t;
`endif

    // Out-of-range WAIT_CYCLES elaborates this empty marker block for inspection.
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_cycles_out_of_range
    end

    function automatic logic addr_error(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
    endfunction

    state_t state, state_nxt;
    logic   accept;
    logic   do_access;
    logic   wr_en;

    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_idx;

    logic [31:0] mem [2**ADDR_W];

`ifdef DMEM_WAIT_STATE_EN
    logic [3:0]  cnt, cnt_nxt;
    logic        we_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  be_p0;

    // Request capture: data path only, never reset
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
            be_p0    <= req_be;
        end
    end

    assign acc_we    = we_p0;
    assign acc_addr  = addr_p0;
    assign acc_wdata = wdata_p0;
    assign acc_be    = be_p0;
`else
    // Access happens on the acceptance edge, straight from the request bus
    assign acc_we    = req_we;
    assign acc_addr  = req_addr;
    assign acc_wdata = req_wdata;
    assign acc_be    = req_be;
`endif

    assign acc_err = addr_error(acc_addr);
    assign acc_idx = acc_addr[ADDR_W+1:2];
    assign accept  = req_valid && req_ready;
    assign wr_en   = do_access && !reset && acc_we && !acc_err;

    always_comb begin
        state_nxt = state;
        do_access = 1'b0;
`ifdef DMEM_WAIT_STATE_EN
        cnt_nxt   = cnt;
`endif
        req_ready = (state == IDLE) && !reset;
        rsp_valid = (state == RESP) && !reset;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DMEM_WAIT_STATE_EN
                    state_nxt = WAIT;
                    cnt_nxt   = WAIT_INIT;
`else
                    state_nxt = RESP;
                    do_access = 1'b1;
`endif
                end
            end
`ifdef DMEM_WAIT_STATE_EN
            WAIT: begin
                if (cnt == 4'd0) begin
                    do_access = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
`endif
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control and response registers; response data is latched once per access and held in RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
`ifdef DMEM_WAIT_STATE_EN
            cnt       <= 4'd0;
`endif
        end else begin
            state <= state_nxt;
`ifdef DMEM_WAIT_STATE_EN
            cnt   <= cnt_nxt;
`endif
            if (do_access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // Byte-lane write port; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: reference word-array model, randomized and directed traffic.
module tb_dmem_responder;
    localparam int ADDR_W      = 8;
    localparam int WAIT_CYCLES = 2;
`ifdef DMEM_WAIT_STATE_EN
    localparam int EXP_LAT = WAIT_CYCLES + 1;
    localparam bit ACCESS_ON_ACCEPT = 1'b0;
`else
    localparam int EXP_LAT = 1;
    localparam bit ACCESS_ON_ACCEPT = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mm [256];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          bp_hold = 1'b0;
    bit          quiet = 1'b0;
    bit          prev_vld = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every valid cycle is compared with the head of the scoreboard
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sbq.size() == 0) begin
                if (!quiet) chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                if (!prev_vld) chk("latency", cyc - sbq[0].acc, EXP_LAT);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, sbq[0].err});
                chk("rsp_rdata", rsp_rdata, sbq[0].rdata);
                if (rsp_ready) void'(sbq.pop_front());
            end
        end
        prev_vld = rsp_valid && !rsp_ready;
    end

    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit abort);
        int   n = 0;
        exp_t e;
        bit   err;
        int   idx;
        req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
        while (!req_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 100) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        err = (a % 4 != 0) || (a >= 32'd4 * 256);
        idx = int'(a / 4) % 256;
        e.err   = err;
        e.rdata = (we || err) ? 32'd0 : mm[idx];
        e.acc   = cyc;
        if (!abort) sbq.push_back(e);
        if (we && !err && (!abort || ACCESS_ON_ACCEPT)) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mm[idx][8*i +: 8] = d[8*i +: 8];
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (sbq.size() != 0 && n < 200);
        if (sbq.size() != 0) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            sbq.delete();
        end
    endtask

    task automatic xfer(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        issue(we, a, d, be, 1'b0);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a;
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Fill memory so the model knows every word
        for (int i = 0; i < 256; i++) xfer(1'b1, 32'(i * 4), $urandom, 4'hF);

        // Full store, read back, partial store
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        xfer(1'b0, 32'h10, 32'h0, 4'h0);
        xfer(1'b1, 32'h10, 32'h0000AA00, 4'b0010);
        xfer(1'b0, 32'h10, 32'h0, 4'hF);
        chk("partial_model", mm[4], 32'hDEADAAEF);
        xfer(1'b1, 32'h14, 32'hFFFFFFFF, 4'b0000);
        xfer(1'b0, 32'h14, 32'h0, 4'h0);

        // Errors: misaligned load, out-of-range store, then word 0
        xfer(1'b0, 32'h12, 32'h0, 4'hF);
        xfer(1'b1, 32'h400, 32'hCAFEF00D, 4'hF);
        xfer(1'b0, 32'h0, 32'h0, 4'h0);

        // Backpressure with an ignored competing request
        bp_hold = 1'b1;
        repeat (2) begin @(negedge clk); #1; end
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); #1; n++; end
        chk("bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            @(negedge clk); #1;
        end
        req_valid = 1'b0;
        bp_hold = 1'b0;
        wait_idle();
        xfer(1'b0, 32'h10, 32'h0, 4'h0);

        // Reset during the wait phase of a store
        quiet = 1'b1;
        issue(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b1);
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        chk("abort_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("abort_rsp_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("abort_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        quiet = 1'b0;
        xfer(1'b0, 32'h20, 32'h0, 4'h0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            n = int'($urandom_range(0, 9));
            a = 32'($urandom_range(0, 255)) * 4;
            if (n == 0) a = a | 32'($urandom_range(1, 3));
            else if (n == 1) a = a | (32'd1 << $urandom_range(10, 31));
            xfer($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
        end

        chk("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
